mem_lsu: RTL and testbench
==========================

// Module: mem_lsu
// PURPOSE
//  Load/store unit sitting directly upstream of mem (addr, wd, we, dt, rd, err).
//  Accepts one load/store request at a time over a valid/ready handshake.
//  Aligned accesses go to mem as a single access.
//  Misaligned half/word accesses are split into sequential byte accesses.
//  Load data is assembled and sign/zero-extended, then returned with an errno_e status.
// PARAMETERS
//  SPLIT_EN  1  1: split misaligned accesses into bytes; 0: reject them with EALIGN, no mem access
// PORTS
//  clk        in   1   clock; all state updates on posedge
//  rst_n      in   1   asynchronous, active-low reset
//  req_valid  in   1   request present
//  req_ready  out  1   unit can accept; high only in IDLE
//  req_we     in   1   1 store, 0 load
//  req_dt     in   mem_dt_e  MEM_DT_BYTE / MEM_DT_HALF / MEM_DT_WORD
//  req_signed in   1   loads only: sign-extend byte/half result
//  req_addr   in   32  byte address
//  req_wd     in   32  store data, right-justified
//  rsp_valid  out  1   one-cycle pulse: response available; no backpressure
//  rsp_rd     out  32  load result (0 for stores)
//  rsp_err    out  errno_e  ENONE, EALIGN, or first error reported by mem
//  m_addr     out  32  to mem addr
//  m_wd       out  32  to mem wd
//  m_we       out  1   to mem we; mem writes on posedge while high
//  m_dt       out  mem_dt_e  to mem dt
//  m_rd       in   32  from mem; combinational, byte/half zero-extended by mem
//  m_err      in   errno_e  from mem, valid in the same cycle as m_rd
// BEHAVIOUR
//  Reset (async, immediate):
//   - state=IDLE; req_ready=1; rsp_valid=0, rsp_rd=0, rsp_err=ENONE
//   - m_we=0; m_addr=0, m_wd=0, m_dt=MEM_DT_WORD
//   - Reset mid-operation abandons the request; byte stores already committed stay written.
//  Accept: on posedge with req_valid&&req_ready, latch we/dt/signed/addr/wd and clear the error register.
//   - misaligned = (HALF && addr[0]) || (WORD && addr[1:0]!=0); BYTE is never misaligned.
//   - Next state: ACCESS if aligned; SPLIT if misaligned && SPLIT_EN; RESP with EALIGN otherwise.
//  ACCESS (1 cycle):
//   - Drive m_addr=addr, m_dt=dt, m_wd=wd, m_we=we.
//   - At posedge: capture m_rd and m_err, go to RESP.
//  SPLIT (N cycles; N=2 half, N=4 word; byte counter k=0..N-1):
//   - Drive m_addr=addr+k (32-bit wrap, 0xFFFFFFFF+1 -> 0), m_dt=MEM_DT_BYTE.
//   - Drive m_wd={24'b0, wd[8k+:8]}, m_we=we.
//   - Load: at posedge, result[8k+:8] <= m_rd[7:0].
//   - If m_err!=ENONE: record it, skip the remaining bytes, go to RESP.
//   - Otherwise go to RESP after k=N-1.
//  RESP (1 cycle):
//   - rsp_valid=1; m_we=0; next state IDLE.
//   - rsp_rd: loads are extended per dt/signed (BYTE bit 7, HALF bit 15; WORD unchanged); stores 0.
//   - rsp_rd is 0 whenever rsp_err!=ENONE.
//  Timing:
//   - m_we is never high outside ACCESS/SPLIT, so each byte is written exactly once.
//   - Latency, accept edge to rsp_valid: aligned 2 cycles, split N+1 cycles, EALIGN reject 1 cycle.
//   - Throughput: a new request can be accepted on the edge after RESP.
//   - rsp_rd/rsp_err hold until the next response; rsp_valid is the only qualifier.
//   - req_valid in non-IDLE states is ignored (req_ready=0).
// TESTING
//  1. mem[12]=0x12345678; store WORD 0xCAFEBABE @48 -> 1 mem write, rsp_valid 2 cycles after accept, mem[12]=0xCAFEBABE
//  2. mem[12]=0x12345678; load HALF signed @50 -> rsp_rd=0x00001234; load BYTE signed @48 with mem[12]=0x000000F0 -> 0xFFFFFFF0
//  3. mem[12]=0x44332211, mem[13]=0x88776655; load WORD @49 -> 4 byte reads at 49..52, rsp_rd=0x55443322, ENONE
//  4. mem[12]=0x12345678; store HALF 0xBEEF @51 -> mem[12]=0xEF345678, mem[13][7:0]=0xBE, other bytes unchanged
//  5. SPLIT_EN=0, load WORD @50 -> rsp_err=EALIGN, rsp_rd=0, m_we stays 0, no mem access
//  6. rst_n low during byte k=1 of a split store @49 -> m_we drops at once; state IDLE; only byte 49 written; req_ready=1

Source files
------------

// File: rtl/mem_lsu.sv
// ============================================================================
// Module   : mem_lsu (with package mem_lsu_pkg)
// Purpose  : Load/store unit in front of a simple memory port. It accepts one
//            request at a time over a valid/ready handshake. Aligned accesses
//            go to memory as a single access. Misaligned half/word accesses
//            are either split into sequential byte accesses or rejected with
//            EALIGN, depending on SPLIT_EN. Load data is sign- or
//            zero-extended before it is returned.
// Ports    : clk, rst_n                 clock, async active-low reset
//            req_valid/req_ready        request handshake (ready only in IDLE)
//            req_we/dt/signed/addr/wd   request fields
//            rsp_valid/rsp_rd/rsp_err   one-cycle response pulse, held data
//            m_addr/m_wd/m_we/m_dt      memory command
//            m_rd/m_err                 combinational memory read data/status
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_lsu_pkg;
  typedef enum logic [1:0] {
    MEM_DT_BYTE = 2'd0,
    MEM_DT_HALF = 2'd1,
    MEM_DT_WORD = 2'd2
  } mem_dt_e;

  typedef enum logic [2:0] {
    ENONE  = 3'd0,
    EALIGN = 3'd1,
    EFAULT = 3'd2,
    EPERM  = 3'd3
  } errno_e;
endpackage

module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  mem_dt_e     req_dt,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wd,
  output logic        rsp_valid,
  output logic [31:0] rsp_rd,
  output errno_e      rsp_err,
  output logic [31:0] m_addr,
  output logic [31:0] m_wd,
  output logic        m_we,
  output mem_dt_e     m_dt,
  input  logic [31:0] m_rd,
  input  errno_e      m_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    SPLIT  = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e      state, state_nxt;
  logic        we;
  mem_dt_e     dt;
  logic        sgn;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] result;
  errno_e      err;
  logic [1:0]  k;
  logic [31:0] rd_hold;
  errno_e      err_hold;
  logic        misaligned;
  logic        last_byte;
  logic [31:0] rd_final;

  assign misaligned = ((req_dt == MEM_DT_HALF) && req_addr[0]) ||
                      ((req_dt == MEM_DT_WORD) && (req_addr[1:0] != 2'b00));

  // Only half and word requests ever enter SPLIT.
  assign last_byte = (dt == MEM_DT_HALF) ? (k == 2'd1) : (k == 2'd3);

  // Extended load result for the request currently being answered.
  always_comb begin
    rd_final = result;
    case (dt)
      MEM_DT_BYTE: rd_final = {{24{sgn & result[7]}}, result[7:0]};
      MEM_DT_HALF: rd_final = {{16{sgn & result[15]}}, result[15:0]};
      default:     rd_final = result;
    endcase
    if (we || (err != ENONE)) rd_final = '0;
  end

  // Responses are visible combinationally during RESP and then held in
  // separate registers, because the working registers are reused as soon as
  // the next request is accepted.
  assign rsp_rd  = (state == RESP) ? rd_final : rd_hold;
  assign rsp_err = (state == RESP) ? err      : err_hold;

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    m_addr    = '0;
    m_wd      = '0;
    m_we      = 1'b0;
    m_dt      = MEM_DT_WORD;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (!misaligned)   state_nxt = ACCESS;
          else if (SPLIT_EN) state_nxt = SPLIT;
          else               state_nxt = RESP;
        end
      end
      ACCESS: begin
        m_addr    = addr;
        m_dt      = dt;
        m_wd      = wd;
        m_we      = we;
        state_nxt = RESP;
      end
      SPLIT: begin
        m_addr = addr + {30'd0, k};
        m_dt   = MEM_DT_BYTE;
        m_wd   = {24'd0, wd[{k, 3'b000} +: 8]};
        m_we   = we;
        if ((m_err != ENONE) || last_byte) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      we       <= 1'b0;
      dt       <= MEM_DT_WORD;
      sgn      <= 1'b0;
      addr     <= '0;
      wd       <= '0;
      result   <= '0;
      err      <= ENONE;
      k        <= 2'd0;
      rd_hold  <= '0;
      err_hold <= ENONE;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we     <= req_we;
            dt     <= req_dt;
            sgn    <= req_signed;
            addr   <= req_addr;
            wd     <= req_wd;
            result <= '0;
            k      <= 2'd0;
            err    <= (misaligned && !SPLIT_EN) ? EALIGN : ENONE;
          end
        end
        ACCESS: begin
          result <= m_rd;
          err    <= m_err;
        end
        SPLIT: begin
          if (!we) result[{k, 3'b000} +: 8] <= m_rd[7:0];
          if (m_err != ENONE) err <= m_err;
          k <= k + 2'd1;
        end
        RESP: begin
          rd_hold  <= rd_final;
          err_hold <= err;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_lsu.sv
// ============================================================================
// Module   : tb_mem_lsu
// Purpose  : Self-checking bench for mem_lsu. It contains a byte-array memory
//            that acts as the downstream memory, and a reference byte array
//            updated by a transaction-level model. The bench runs directed
//            cases first and then randomized requests. A second instance
//            with SPLIT_EN=0 covers the reject path.
// Ports    : none
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_we, req_signed, rsp_valid, m_we;
  mem_dt_e     req_dt, m_dt;
  logic [31:0] req_addr, req_wd, rsp_rd, m_addr, m_wd, m_rd;
  errno_e      rsp_err, m_err;

  logic        n_req_valid, n_req_ready, n_req_we, n_req_signed, n_rsp_valid, n_m_we;
  mem_dt_e     n_req_dt, n_m_dt;
  logic [31:0] n_req_addr, n_req_wd, n_rsp_rd, n_m_addr, n_m_wd, n_m_rd;
  errno_e      n_rsp_err, n_m_err;

  logic [7:0]  tb_mem  [256];
  logic [7:0]  ref_mem [256];
  logic [31:0] exp_addrs [$];
  int checks = 0;
  int errors = 0;

  mem_lsu #(.SPLIT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_dt(req_dt), .req_signed(req_signed),
    .req_addr(req_addr), .req_wd(req_wd), .rsp_valid(rsp_valid),
    .rsp_rd(rsp_rd), .rsp_err(rsp_err), .m_addr(m_addr), .m_wd(m_wd),
    .m_we(m_we), .m_dt(m_dt), .m_rd(m_rd), .m_err(m_err)
  );

  mem_lsu #(.SPLIT_EN(1'b0)) dut_ns (
    .clk(clk), .rst_n(rst_n), .req_valid(n_req_valid), .req_ready(n_req_ready),
    .req_we(n_req_we), .req_dt(n_req_dt), .req_signed(n_req_signed),
    .req_addr(n_req_addr), .req_wd(n_req_wd), .rsp_valid(n_rsp_valid),
    .rsp_rd(n_rsp_rd), .rsp_err(n_rsp_err), .m_addr(n_m_addr), .m_wd(n_m_wd),
    .m_we(n_m_we), .m_dt(n_m_dt), .m_rd(n_m_rd), .m_err(n_m_err)
  );

  // The reject-only instance must never reach memory on misaligned requests;
  // its read data is a fixed marker so aligned loads are still observable.
  assign n_m_rd  = 32'hA5A5_5A5A;
  assign n_m_err = ENONE;

  // Bytes 0xE0..0xEF of every 256-byte page report a fault.
  function automatic bit fault(input logic [31:0] a);
    return a[7:4] == 4'hE;
  endfunction

  function automatic int nbytes(input mem_dt_e dt);
    return (dt == MEM_DT_BYTE) ? 1 : ((dt == MEM_DT_HALF) ? 2 : 4);
  endfunction

  always_comb begin
    m_err = ENONE;
    m_rd  = '0;
    if (fault(m_addr)) m_err = EFAULT;
    else begin
      case (m_dt)
        MEM_DT_BYTE: m_rd = {24'd0, tb_mem[m_addr[7:0]]};
        MEM_DT_HALF: m_rd = {16'd0, tb_mem[m_addr[7:0] + 8'd1], tb_mem[m_addr[7:0]]};
        default:     m_rd = {tb_mem[m_addr[7:0] + 8'd3], tb_mem[m_addr[7:0] + 8'd2],
                             tb_mem[m_addr[7:0] + 8'd1], tb_mem[m_addr[7:0]]};
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: sample the memory command, let the edge pass, then commit the
  // write into the bench memory and return at the next falling edge.
  task automatic tick();
    logic        do_wr;
    logic [31:0] wa, wdat;
    int          n;
    #1;
    do_wr = m_we && !fault(m_addr);
    wa    = m_addr;
    wdat  = m_wd;
    n     = nbytes(m_dt);
    @(posedge clk);
    #1;
    if (do_wr) begin
      for (int i = 0; i < n; i++) begin
        logic [31:0] ba;
        ba = wa + 32'(i);
        tb_mem[ba[7:0]] = 8'(wdat >> (8 * i));
      end
    end
    @(negedge clk);
  endtask

  task automatic set_word(input logic [7:0] a, input logic [31:0] v);
    for (int i = 0; i < 4; i++) begin
      tb_mem[a + 8'(i)]  = 8'(v >> (8 * i));
      ref_mem[a + 8'(i)] = 8'(v >> (8 * i));
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {tb_mem[a + 8'd3], tb_mem[a + 8'd2], tb_mem[a + 8'd1], tb_mem[a]};
  endfunction

  // Transaction-level reference: which bytes are touched, what gets stored,
  // what a load returns, and how many cycles the response takes.
  task automatic model(input logic we, input mem_dt_e dt, input logic sg,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output errno_e er, output int lat);
    int          n;
    bit          mis;
    logic [31:0] v, ai;
    n   = nbytes(dt);
    mis = (a % n) != 0;
    v   = 0;
    rd  = 0;
    er  = ENONE;
    exp_addrs.delete();
    if (!mis) begin
      exp_addrs.push_back(a);
      lat = 2;
      if (fault(a)) er = EFAULT;
      else begin
        for (int i = 0; i < n; i++) begin
          ai = a + 32'(i);
          if (we) ref_mem[ai[7:0]] = 8'(d >> (8 * i));
          else    v = v + (32'(ref_mem[ai[7:0]]) << (8 * i));
        end
      end
    end else begin
      for (int i = 0; i < n; i++) begin
        ai = a + 32'(i);
        exp_addrs.push_back(ai);
        if (fault(ai)) begin
          er = EFAULT;
          break;
        end
        if (we) ref_mem[ai[7:0]] = 8'(d >> (8 * i));
        else    v = v + (32'(ref_mem[ai[7:0]]) << (8 * i));
      end
      lat = exp_addrs.size() + 1;
    end
    if (sg && n == 1 && v >= 32'd128)   v = v - 32'h100;
    if (sg && n == 2 && v >= 32'd32768) v = v - 32'h10000;
    if (er == ENONE && !we) rd = v;
  endtask

  task automatic run_txn(input logic we, input mem_dt_e dt, input logic sg,
                         input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] got_rd, output int n_wr);
    logic [31:0] erd;
    errno_e      eer;
    int          elat, cyc, diffs, na;
    bit          split;
    logic [31:0] ga [$];
    logic [31:0] gwd [$];
    mem_dt_e     gdt [$];
    logic        gwe [$];
    model(we, dt, sg, a, d, erd, eer, elat);
    split = (a % nbytes(dt)) != 0;
    check("req_ready", req_ready, 1'b1);
    req_valid = 1'b1; req_we = we; req_dt = dt; req_signed = sg;
    req_addr = a; req_wd = d;
    tick();
    req_valid = 1'b0;
    cyc = 1;
    while (!rsp_valid && cyc < 12) begin
      ga.push_back(m_addr); gdt.push_back(m_dt); gwe.push_back(m_we); gwd.push_back(m_wd);
      tick();
      cyc++;
    end
    got_rd = rsp_rd;
    check("latency", cyc, elat);
    check("rsp_err", rsp_err, eer);
    check("rsp_rd", rsp_rd, erd);
    check("we_in_resp", m_we, 1'b0);
    check("n_access", ga.size(), exp_addrs.size());
    na = (ga.size() < exp_addrs.size()) ? ga.size() : exp_addrs.size();
    n_wr = 0;
    for (int i = 0; i < na; i++) begin
      check("m_addr", ga[i], exp_addrs[i]);
      check("m_dt", gdt[i], split ? MEM_DT_BYTE : dt);
      check("m_we", gwe[i], we);
      if (we) check("m_wd", gwd[i], split ? {24'd0, 8'(d >> (8 * i))} : d);
      if (gwe[i]) n_wr++;
    end
    tick();
    check("rsp_pulse", rsp_valid, 1'b0);
    check("rd_hold", rsp_rd, erd);
    check("err_hold", rsp_err, eer);
    diffs = 0;
    for (int i = 0; i < 256; i++) if (tb_mem[i] !== ref_mem[i]) diffs++;
    check("mem_contents", diffs, 0);
  endtask

  task automatic run_ns(input logic we, input mem_dt_e dt, input logic [31:0] a);
    int cyc;
    bit any_we, mis;
    mis = (a % nbytes(dt)) != 0;
    any_we = 1'b0;
    check("ns_ready", n_req_ready, 1'b1);
    n_req_valid = 1'b1; n_req_we = we; n_req_dt = dt; n_req_signed = 1'b0;
    n_req_addr = a; n_req_wd = 32'h1357_9BDF;
    tick();
    n_req_valid = 1'b0;
    cyc = 1;
    while (!n_rsp_valid && cyc < 12) begin
      any_we |= n_m_we;
      tick();
      cyc++;
    end
    any_we |= n_m_we;
    check("ns_latency", cyc, mis ? 1 : 2);
    check("ns_err", n_rsp_err, mis ? EALIGN : ENONE);
    check("ns_rd", n_rsp_rd, (mis || we) ? 32'd0 : 32'hA5A5_5A5A);
    check("ns_we", any_we, we && !mis);
    tick();
  endtask

  initial begin
    logic [31:0] rd, a;
    int          nw;
    req_valid = 0; req_we = 0; req_dt = MEM_DT_WORD; req_signed = 0; req_addr = 0; req_wd = 0;
    n_req_valid = 0; n_req_we = 0; n_req_dt = MEM_DT_WORD; n_req_signed = 0;
    n_req_addr = 0; n_req_wd = 0;
    for (int i = 0; i < 256; i++) begin
      tb_mem[i]  = 8'($urandom);
      ref_mem[i] = tb_mem[i];
    end
    tick();
    tick();
    check("rst_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_rd", rsp_rd, 32'd0);
    check("rst_rsp_err", rsp_err, ENONE);
    check("rst_m_we", m_we, 1'b0);
    check("rst_m_addr", m_addr, 32'd0);
    check("rst_m_wd", m_wd, 32'd0);
    check("rst_m_dt", m_dt, MEM_DT_WORD);
    rst_n = 1'b1;
    tick();

    set_word(8'd48, 32'h1234_5678);
    run_txn(1'b1, MEM_DT_WORD, 1'b0, 32'd48, 32'hCAFE_BABE, rd, nw);
    check("t1_writes", nw, 1);
    check("t1_mem", mem_word(8'd48), 32'hCAFE_BABE);

    set_word(8'd48, 32'h1234_5678);
    run_txn(1'b0, MEM_DT_HALF, 1'b1, 32'd50, 32'd0, rd, nw);
    check("t2_half", rd, 32'h0000_1234);
    set_word(8'd48, 32'h0000_00F0);
    run_txn(1'b0, MEM_DT_BYTE, 1'b1, 32'd48, 32'd0, rd, nw);
    check("t2_byte", rd, 32'hFFFF_FFF0);

    set_word(8'd48, 32'h4433_2211);
    set_word(8'd52, 32'h8877_6655);
    run_txn(1'b0, MEM_DT_WORD, 1'b0, 32'd49, 32'd0, rd, nw);
    check("t3_word", rd, 32'h5544_3322);

    set_word(8'd48, 32'h1234_5678);
    set_word(8'd52, 32'h8877_6655);
    run_txn(1'b1, MEM_DT_HALF, 1'b0, 32'd51, 32'h0000_BEEF, rd, nw);
    check("t4_w12", mem_word(8'd48), 32'hEF34_5678);
    check("t4_w13", mem_word(8'd52), 32'h8877_66BE);

    run_ns(1'b0, MEM_DT_WORD, 32'd50);
    run_ns(1'b1, MEM_DT_HALF, 32'd51);
    run_ns(1'b0, MEM_DT_WORD, 32'd52);

    // Reset in the middle of a split store: only the first byte lands.
    set_word(8'd48, 32'h1122_3344);
    set_word(8'd52, 32'h5566_7788);
    req_valid = 1'b1; req_we = 1'b1; req_dt = MEM_DT_WORD; req_signed = 1'b0;
    req_addr = 32'd49; req_wd = 32'hAABB_CCDD;
    tick();
    req_valid = 1'b0;
    tick();
    check("t6_addr_k1", m_addr, 32'd50);
    rst_n = 1'b0;
    #1;
    check("t6_we_drop", m_we, 1'b0);
    check("t6_ready", req_ready, 1'b1);
    check("t6_rsp_valid", rsp_valid, 1'b0);
    tick();
    check("t6_w12", mem_word(8'd48), 32'h1122_DD44);
    check("t6_w13", mem_word(8'd52), 32'h5566_7788);
    ref_mem[49] = 8'hDD;
    rst_n = 1'b1;
    tick();

    for (int t = 0; t < 300; t++) begin
      logic [23:0] hi;
      case ($urandom_range(0, 3))
        0:       hi = 24'hFF_FFFF;
        1:       hi = 24'h00_0000;
        default: hi = 24'($urandom);
      endcase
      a = {hi, 8'($urandom)};
      run_txn(1'($urandom), mem_dt_e'($urandom_range(0, 2)), 1'($urandom),
              a, $urandom, rd, nw);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
